// File: rtl/hilo_commit_stage.sv
// rtl/hilo_commit_stage.sv - HI/LO commit stage behind the array multipliers
// Waits out the multiplier settle time, commits the product, serves mfhi/mflo/mthi/mtlo.
module hilo_commit_stage #(
   parameter int MULT_LAT = 4,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mult_start,
   input  logic        signed_op,
   input  logic [63:0] prod_s,
   input  logic [63:0] prod_u,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        mfhi,
   input  logic        mflo,
   output logic [31:0] rdata,
   output logic        rd_valid,
   output logic        busy,
   output logic        done,
   output logic        stall,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sel_q, sel_d;
   logic [31:0]        hi_d, lo_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               rd_valid_q, rd_valid_d;
   logic [63:0]        product;
   logic               any_req;

   assign product  = sel_q ? prod_s : prod_u;
   assign any_req  = mult_start | mthi | mtlo | mfhi | mflo;
   assign busy     = (state_q == ST_BUSY);
   assign done     = (state_q == ST_DONE);
   assign stall    = busy & any_req;
   assign rdata    = rdata_q;
   assign rd_valid = rd_valid_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      rdata_d    = rdata_q;
      rd_valid_d = 1'b0;

      case (state_q)
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               hi_d    = product[63:32];
               lo_d    = product[31:0];
               state_d = ST_DONE;
            end
         end
         default: begin
            // Reads see the pre-write register value; a later commit overwrites any write here.
            if (mfhi) begin
               rdata_d    = hi_q;
               rd_valid_d = 1'b1;
            end else if (mflo) begin
               rdata_d    = lo_q;
               rd_valid_d = 1'b1;
            end
            if (mthi) hi_d = wdata;
            if (mtlo) lo_d = wdata;
            if (mult_start) begin
               sel_d   = signed_op;
               cnt_d   = CNT_W'(MULT_LAT - 1);
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sel_q      <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         rdata_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         rdata_q    <= rdata_d;
         rd_valid_q <= rd_valid_d;
      end
   end

endmodule

// File: tb/tb_hilo_commit_stage.sv
// tb/tb_hilo_commit_stage.sv - directed bench for hilo_commit_stage
module tb_hilo_commit_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mult_start = 1'b0;
   logic        signed_op = 1'b0;
   logic [63:0] prod_s = '0;
   logic [63:0] prod_u = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wdata = '0;
   logic        mfhi = 1'b0;
   logic        mflo = 1'b0;
   logic [31:0] rdata;
   logic        rd_valid;
   logic        busy;
   logic        done;
   logic        stall;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   int checks = 0;
   int errors = 0;

   hilo_commit_stage #(.MULT_LAT(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .mult_start(mult_start), .signed_op(signed_op),
      .prod_s(prod_s), .prod_u(prod_u), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .mfhi(mfhi), .mflo(mflo), .rdata(rdata), .rd_valid(rd_valid), .busy(busy),
      .done(done), .stall(stall), .hi_q(hi_q), .lo_q(lo_q)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (hi_q !== 32'h0 || lo_q !== 32'h0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_regs hi=%h lo=%h rdata=%h expected all 0", hi_q, lo_q, rdata);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags busy=%b done=%b rd_valid=%b stall=%b expected 0000",
                  busy, done, rd_valid, stall);
      end
      tick();
   endtask

   task automatic test_signed_commit();
      signed_op  = 1'b1;
      prod_s     = 64'hFFFF_FFFF_FFFF_FFF1;
      prod_u     = 64'h1111_2222_3333_4444;
      mult_start = 1'b1;
      tick();
      mult_start = 1'b0;
      signed_op  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0 || hi_q !== 32'h0) begin
            errors++;
            $display("FAIL signed_busy cyc=%0d busy=%b done=%b hi=%h expected 1 0 0", i, busy, done, hi_q);
         end
         tick();
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL signed_done busy=%b done=%b expected 0 1", busy, done);
      end
      checks++;
      if (hi_q !== 32'hFFFF_FFFF || lo_q !== 32'hFFFF_FFF1) begin
         errors++;
         $display("FAIL signed_hilo hi=%h lo=%h expected ffffffff fffffff1", hi_q, lo_q);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL signed_idle done=%b busy=%b expected 0 0", done, busy);
      end
      mfhi = 1'b1;
      tick();
      mfhi = 1'b0;
      checks++;
      if (rdata !== 32'hFFFF_FFFF || rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL signed_mfhi rdata=%h rd_valid=%b expected ffffffff 1", rdata, rd_valid);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_valid_pulse rd_valid=%b expected 0", rd_valid);
      end
   endtask

   task automatic test_back_to_back();
      signed_op  = 1'b0;
      prod_u     = 64'h0000_0001_0000_0000;
      prod_s     = 64'h7777_7777_7777_7777;
      mult_start = 1'b1;
      tick();
      mult_start = 1'b0;
      repeat (4) tick();
      checks++;
      if (done !== 1'b1 || hi_q !== 32'h1 || lo_q !== 32'h0) begin
         errors++;
         $display("FAIL unsigned_commit done=%b hi=%h lo=%h expected 1 00000001 00000000", done, hi_q, lo_q);
      end
      signed_op  = 1'b1;
      prod_s     = 64'd15;
      mult_start = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL done_start_stall stall=%b expected 0", stall);
      end
      tick();
      mult_start = 1'b0;
      signed_op  = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_gap busy=%b done=%b expected 1 0", busy, done);
      end
      repeat (3) tick();
      checks++;
      if (busy !== 1'b1 || hi_q !== 32'h1) begin
         errors++;
         $display("FAIL b2b_still_busy busy=%b hi=%h expected 1 00000001", busy, hi_q);
      end
      tick();
      checks++;
      if (done !== 1'b1 || hi_q !== 32'h0 || lo_q !== 32'd15) begin
         errors++;
         $display("FAIL b2b_commit done=%b hi=%h lo=%h expected 1 00000000 0000000f", done, hi_q, lo_q);
      end
      tick();
   endtask

   task automatic test_stall_busy();
      mfhi = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_stall stall=%b expected 0", stall);
      end
      mfhi       = 1'b0;
      signed_op  = 1'b0;
      prod_u     = 64'h0000_00AA_0000_00BB;
      prod_s     = 64'h0000_00CC_0000_00DD;
      mult_start = 1'b1;
      tick();
      mult_start = 1'b0;
      mthi  = 1'b1;
      wdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_mthi stall=%b expected 1", stall);
      end
      tick();
      mthi = 1'b0;
      mflo = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1 || hi_q !== 32'h0) begin
         errors++;
         $display("FAIL stall_mflo stall=%b hi=%h expected 1 00000000", stall, hi_q);
      end
      tick();
      mflo = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_no_read rd_valid=%b expected 0", rd_valid);
      end
      mult_start = 1'b1;
      signed_op  = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_start stall=%b expected 1", stall);
      end
      tick();
      mult_start = 1'b0;
      signed_op  = 1'b0;
      tick();
      checks++;
      if (done !== 1'b1 || hi_q !== 32'h0000_00AA || lo_q !== 32'h0000_00BB) begin
         errors++;
         $display("FAIL stall_result done=%b hi=%h lo=%h expected 1 000000aa 000000bb", done, hi_q, lo_q);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL stall_ignored_start busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_rw_hazard();
      mthi  = 1'b1;
      wdata = 32'h0000_1234;
      tick();
      mthi  = 1'b1;
      mfhi  = 1'b1;
      wdata = 32'h0000_5678;
      tick();
      mthi  = 1'b0;
      mfhi  = 1'b0;
      checks++;
      if (rdata !== 32'h0000_1234 || rd_valid !== 1'b1 || hi_q !== 32'h0000_5678) begin
         errors++;
         $display("FAIL rw_hazard rdata=%h rd_valid=%b hi=%h expected 00001234 1 00005678",
                  rdata, rd_valid, hi_q);
      end
      mfhi = 1'b1;
      mflo = 1'b1;
      tick();
      mfhi = 1'b0;
      mflo = 1'b0;
      checks++;
      if (rdata !== 32'h0000_5678 || rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL mfhi_priority rdata=%h rd_valid=%b expected 00005678 1", rdata, rd_valid);
      end
      mthi  = 1'b1;
      mtlo  = 1'b1;
      wdata = 32'hCAFE_F00D;
      tick();
      mthi  = 1'b0;
      mtlo  = 1'b0;
      checks++;
      if (hi_q !== 32'hCAFE_F00D || lo_q !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL mthi_mtlo_both hi=%h lo=%h expected cafef00d cafef00d", hi_q, lo_q);
      end
      mflo = 1'b1;
      tick();
      mflo = 1'b0;
      checks++;
      if (rdata !== 32'hCAFE_F00D || rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL mflo_read rdata=%h rd_valid=%b expected cafef00d 1", rdata, rd_valid);
      end
      tick();
   endtask

   task automatic test_start_with_write();
      signed_op  = 1'b0;
      prod_u     = 64'h0000_0042_0000_0043;
      mult_start = 1'b1;
      mtlo       = 1'b1;
      wdata      = 32'h0BAD_0BAD;
      tick();
      mult_start = 1'b0;
      mtlo       = 1'b0;
      checks++;
      if (lo_q !== 32'h0BAD_0BAD || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_write_now lo=%h busy=%b expected 0bad0bad 1", lo_q, busy);
      end
      repeat (4) tick();
      checks++;
      if (hi_q !== 32'h0000_0042 || lo_q !== 32'h0000_0043) begin
         errors++;
         $display("FAIL start_write_overwrite hi=%h lo=%h expected 00000042 00000043", hi_q, lo_q);
      end
      tick();
   endtask

   task automatic test_async_reset_mid();
      signed_op  = 1'b1;
      prod_s     = 64'h1234_5678_9ABC_DEF0;
      mult_start = 1'b1;
      tick();
      mult_start = 1'b0;
      signed_op  = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi_q !== 32'h0 || lo_q !== 32'h0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL async_reset busy=%b done=%b hi=%h lo=%h rdata=%h expected all 0",
                  busy, done, hi_q, lo_q, rdata);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || hi_q !== 32'h0 || lo_q !== 32'h0) begin
            errors++;
            $display("FAIL post_reset cyc=%0d done=%b busy=%b hi=%h lo=%h expected 0 0 0 0",
                     i, done, busy, hi_q, lo_q);
         end
      end
   endtask

   initial begin
      test_reset();
      test_signed_commit();
      test_back_to_back();
      test_stall_busy();
      test_rw_hazard();
      test_start_with_write();
      test_async_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hilo_commit_stage.md
Name: hilo_commit_stage

Overview:
- Execute-stage block directly downstream of the signed/unsigned array multipliers in the RISC datapath.
- Models the multiplier settle time with a latency counter, then commits the selected 64-bit product into architectural HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes, with busy/stall handshakes to the pipeline control.
- Upstream holds operands stable while busy is high, so the product inputs are valid whenever they are sampled.

Parameters:
- MULT_LAT, 4: cycles from an accepted start to the HI/LO commit edge (legal range 1..15).
- CNT_W, 4: latency counter width; must satisfy 2^CNT_W > MULT_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mult_start  in  1  request a multiply commit.
- signed_op  in  1  1 = commit prod_s, 0 = commit prod_u; sampled with mult_start.
- prod_s  in  64  signed multiplier product.
- prod_u  in  64  unsigned multiplier product.
- mthi  in  1  write wdata into HI.
- mtlo  in  1  write wdata into LO.
- wdata  in  32  data for mthi/mtlo.
- mfhi  in  1  read HI.
- mflo  in  1  read LO.
- rdata  out  32  read data, registered.
- rd_valid  out  1  one-cycle pulse; rdata is valid while it is high.
- busy  out  1  multiply in flight.
- done  out  1  one-cycle pulse after commit.
- stall  out  1  combinational; a request this cycle was refused.
- hi_q  out  32  current HI.
- lo_q  out  32  current LO.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0.
  - hi_q, lo_q, rdata = 0.
  - rd_valid, busy, done = 0.
  - Applies immediately, including mid-multiply; the in-flight multiply is discarded.
- FSM states IDLE, BUSY, DONE; busy=1 iff state==BUSY; done=1 iff state==DONE.
- IDLE or DONE, mult_start=1:
  - Latch signed_op into sel_q, set cnt=MULT_LAT-1, go to BUSY.
  - Back-to-back starts from DONE are legal.
- BUSY, cnt!=0: cnt decrements each cycle.
- BUSY, cnt==0:
  - Select the product with sel_q: sel_q=1 takes prod_s, sel_q=0 takes prod_u.
  - On the next edge, hi_q <= product[63:32], lo_q <= product[31:0], and state goes to DONE.
- DONE with no mult_start: go to IDLE after one cycle.
- Timing: start sampled at edge E0 gives busy high for exactly MULT_LAT cycles, HI/LO updated at edge E(MULT_LAT), and done high for the following cycle.
- mult_start while BUSY: ignored; stall=1 that cycle.
- Reads (mfhi/mflo) in IDLE or DONE:
  - rdata <= hi_q or lo_q at the next edge, with rd_valid=1 for one cycle.
  - If mfhi and mflo are both high, mfhi wins.
- Writes (mthi/mtlo) in IDLE or DONE: update at the next edge. mthi and mtlo together update both.
- Any mfhi, mflo, mthi or mtlo while BUSY: dropped, stall=1, rd_valid=0, HI/LO unchanged.
- Same-cycle read and write of the same register: read returns the old value (read-before-write).
- mult_start and mthi/mtlo in the same IDLE cycle: the write applies now, and the later commit overwrites it.
- A DONE-cycle write that coincides with a new start: the write applies; the new commit later overwrites it.
- stall never depends on rd_valid or done. No other outputs change outside the cases above.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, release → hi_q=lo_q=rdata=0, busy=done=rd_valid=0.
- Signed commit, MULT_LAT=4: signed_op=1, prod_s=64'hFFFF_FFFF_FFFF_FFF1 (-3*5), pulse mult_start at E0 → busy high E0..E4, hi_q=32'hFFFF_FFFF and lo_q=32'hFFFF_FFF1 at E4, done high one cycle, then mfhi gives rdata=32'hFFFF_FFFF with rd_valid the next cycle.
- Unsigned and back-to-back: commit prod_u=64'h0000_0001_0000_0000, then assert mult_start during DONE with signed_op=1, prod_s=64'd15 → second BUSY starts with no IDLE gap, final hi_q=0, lo_q=15.
- Stall during busy: mthi(wdata=32'hDEAD_BEEF), mflo and mult_start each asserted while BUSY → stall=1 each cycle, rd_valid=0, final HI/LO equal to the multiply result only.
- Read/write hazard: in IDLE with hi_q=32'h1234, mfhi and mthi(wdata=32'h5678) in the same cycle → rdata=32'h1234, hi_q=32'h5678 afterwards; mfhi+mflo together → HI returned.
- Async reset mid-multiply: drop rst_n at cnt==1 → outputs zero immediately, no done pulse, HI/LO stay 0 after release.
